// File: rtl/neureka_streamout_realigner_pkg.sv
// Shared types and default widths for the store_out realigner.
//   REALIGN_BW   : beat width in bits (multiple of 8)
//   REALIGN_LENW : width of the per-tile beat-count field
//   realign_state_t : IDLE -> STREAM -> (FLUSH) -> DONE -> IDLE
//   ctrl_realign_t  : tile command {offset, len, start}
//   flags_realign_t : status {busy, done}
package neureka_streamout_realigner_pkg;

  localparam int unsigned REALIGN_BW   = 256;
  localparam int unsigned REALIGN_NB   = REALIGN_BW / 8;
  localparam int unsigned REALIGN_OFFW = $clog2(REALIGN_NB);
  localparam int unsigned REALIGN_LENW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } realign_state_t;

  typedef struct packed {
    logic [REALIGN_OFFW-1:0] offset;
    logic [REALIGN_LENW-1:0] len;
    logic                    start;
  } ctrl_realign_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_realign_t;

endpackage

// File: rtl/neureka_streamout_realigner_rotator.sv
// neureka_byte_rotator: combinational byte realignment.
//   cat_data_i / cat_strb_i : {push, carry} (push in the upper half)
//   offset_i                : byte offset o of the destination base
//   aligned_data_o/_strb_o  : carry bytes 0..o-1, then push bytes 0..NB-o-1
//   carry_data_o/_strb_o    : push bytes NB-o..NB-1 moved to bytes 0..o-1,
//                             upper bytes zero
module neureka_byte_rotator #(
  parameter int unsigned BW = 256
) (
  input  logic [2*BW-1:0]          cat_data_i,
  input  logic [2*(BW/8)-1:0]      cat_strb_i,
  input  logic [$clog2(BW/8)-1:0]  offset_i,
  output logic [BW-1:0]            aligned_data_o,
  output logic [BW/8-1:0]          aligned_strb_o,
  output logic [BW-1:0]            carry_data_o,
  output logic [BW/8-1:0]          carry_strb_o
);

  localparam int unsigned NB = BW / 8;

  logic [2*BW-1:0] wide_data;
  logic [2*NB-1:0] wide_strb;
  logic [NB-1:0]   lo_mask;
  logic [BW-1:0]   lo_data_mask;

  always_comb begin
    // Shifting the push beat up by o bytes into a double-width word puts
    // the part that lands in this memory word in the low half and the
    // spill-over (next carry) in the high half.
    wide_data = {{BW{1'b0}}, cat_data_i[2*BW-1:BW]} << {offset_i, 3'b000};
    wide_strb = {{NB{1'b0}}, cat_strb_i[2*NB-1:NB]} << offset_i;
    // Only carry bytes below o are meaningful; mask the rest defensively.
    lo_mask   = ~({NB{1'b1}} << offset_i);
    for (int b = 0; b < int'(NB); b++) begin
      lo_data_mask[8*b +: 8] = {8{lo_mask[b]}};
    end
    aligned_data_o = wide_data[BW-1:0] | (cat_data_i[BW-1:0] & lo_data_mask);
    aligned_strb_o = wide_strb[NB-1:0] | (cat_strb_i[NB-1:0] & lo_mask);
    carry_data_o   = wide_data[2*BW-1:BW];
    carry_strb_o   = wide_strb[2*NB-1:NB];
  end

endmodule

// File: rtl/neureka_streamout_realigner.sv
// neureka_streamout_realigner: realigns the engine store_out stream to a
// byte-misaligned TCDM base and emits memory-aligned words with strobes.
//   clk_i, rst_i (async, active-high), clear_i (sync clear), enable_i
//   start_i/offset_i/len_i      : tile command, honoured in IDLE only
//   push_*                      : input beats (valid/ready)
//   pop_*                       : aligned output words (valid/ready)
//   busy_o, done_o              : status; done_o is a 1-cycle pulse
// Handshake: a beat moves on valid & ready. pop_valid_o, once high, stays
// high with stable data/strb until pop_ready_i is seen while enabled.
module neureka_streamout_realigner
  import neureka_streamout_realigner_pkg::*;
#(
  parameter int unsigned BW   = REALIGN_BW,
  parameter int unsigned LENW = REALIGN_LENW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [$clog2(BW/8)-1:0]  offset_i,
  input  logic [LENW-1:0]          len_i,
  input  logic [BW-1:0]            push_data_i,
  input  logic [BW/8-1:0]          push_strb_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  output logic [BW-1:0]            pop_data_o,
  output logic [BW/8-1:0]          pop_strb_o,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned NB   = BW / 8;
  localparam int unsigned OFFW = $clog2(NB);

  realign_state_t  state_q, state_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [LENW-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [BW-1:0]   carry_q, carry_d, pop_data_q, pop_data_d;
  logic [NB-1:0]   carry_strb_q, carry_strb_d, pop_strb_q, pop_strb_d;
  logic            pop_valid_q, pop_valid_d, done_q, done_d;

  ctrl_realign_t   ctrl;
  flags_realign_t  flags;

  logic [BW-1:0]   rot_data, rot_carry;
  logic [NB-1:0]   rot_strb, rot_carry_strb;
  logic            out_free, push_fire;

  assign ctrl.offset = offset_i;
  assign ctrl.len    = len_i;
  assign ctrl.start  = start_i;

  neureka_byte_rotator #(.BW(BW)) u_rotator (
    .cat_data_i     ({push_data_i, carry_q}),
    .cat_strb_i     ({push_strb_i, carry_strb_q}),
    .offset_i       (off_q),
    .aligned_data_o (rot_data),
    .aligned_strb_o (rot_strb),
    .carry_data_o   (rot_carry),
    .carry_strb_o   (rot_carry_strb)
  );

  // The output register can take a new word when empty or draining now.
  assign out_free     = ~pop_valid_q | pop_ready_i;
  assign push_ready_o = enable_i & (state_q == STREAM) & out_free;
  assign push_fire    = push_ready_o & push_valid_i;

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    carry_strb_d = carry_strb_q;
    pop_data_d   = pop_data_q;
    pop_strb_d   = pop_strb_q;
    pop_valid_d  = pop_valid_q;
    done_d       = 1'b0;
    if (enable_i) begin
      if (pop_valid_q && pop_ready_i) pop_valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ctrl.start) begin
            if (ctrl.len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d      = STREAM;
              off_d        = ctrl.offset;
              len_d        = ctrl.len;
              cnt_d        = '0;
              carry_d      = '0;
              carry_strb_d = '0;
            end
          end
        end
        STREAM: begin
          if (push_fire) begin
            pop_data_d   = rot_data;
            pop_strb_d   = rot_strb;
            pop_valid_d  = 1'b1;
            carry_d      = rot_carry;
            carry_strb_d = rot_carry_strb;
            cnt_d        = cnt_q + 1'b1;
            // A flush beat is only worth emitting if the tail carries
            // at least one enabled byte.
            if (cnt_d == len_q) begin
              state_d = ((off_q != '0) && (rot_carry_strb != '0)) ? FLUSH : DONE;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            pop_data_d   = carry_q;
            pop_strb_d   = carry_strb_q;
            pop_valid_d  = 1'b1;
            carry_d      = '0;
            carry_strb_d = '0;
            state_d      = DONE;
          end
        end
        DONE: begin
          if (out_free) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      off_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      carry_q      <= '0;
      carry_strb_q <= '0;
      pop_data_q   <= '0;
      pop_strb_q   <= '0;
      pop_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else if (clear_i) begin
      state_q      <= IDLE;
      off_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      carry_q      <= '0;
      carry_strb_q <= '0;
      pop_data_q   <= '0;
      pop_strb_q   <= '0;
      pop_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      carry_strb_q <= carry_strb_d;
      pop_data_q   <= pop_data_d;
      pop_strb_q   <= pop_strb_d;
      pop_valid_q  <= pop_valid_d;
      done_q       <= done_d;
    end
  end

  assign flags.busy  = (state_q == STREAM) || (state_q == FLUSH);
  assign flags.done  = done_q;
  assign busy_o      = flags.busy;
  assign done_o      = flags.done;
  assign pop_data_o  = pop_data_q;
  assign pop_strb_o  = pop_strb_q;
  assign pop_valid_o = pop_valid_q;

endmodule

// File: tb/tb_neureka_streamout_realigner.sv
// Bench for neureka_streamout_realigner. The reference model places every
// input byte at linear address o + beat*NB + byte and slices that address
// space into NB-byte memory words.
module tb_neureka_streamout_realigner;

  localparam int BW   = 256;
  localparam int NB   = BW / 8;
  localparam int LENW = 16;
  localparam int W    = BW + NB;

  logic              clk_i, rst_i, enable_i, clear_i, start_i;
  logic [4:0]        offset_i;
  logic [LENW-1:0]   len_i;
  logic [BW-1:0]     push_data_i;
  logic [NB-1:0]     push_strb_i;
  logic              push_valid_i, push_ready_o;
  logic [BW-1:0]     pop_data_o;
  logic [NB-1:0]     pop_strb_o;
  logic              pop_valid_o, pop_ready_i, busy_o, done_o;

  neureka_streamout_realigner dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .start_i(start_i), .offset_i(offset_i), .len_i(len_i),
    .push_data_i(push_data_i), .push_strb_i(push_strb_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .pop_data_o(pop_data_o), .pop_strb_o(pop_strb_o),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- shared state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [BW-1:0] in_d[$];
  logic [NB-1:0] in_s[$];
  int          bp_pct = 0, en_pct = 0;
  bit          force_en = 0, abort = 0, expect_done = 0, zero_len = 0;
  int          done_cnt = 0, cyc = 0, last_pop_cyc = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Behavioural model: linear byte-address placement.
  task automatic model_tile(input int o, input int len);
    int nout, src;
    logic [BW-1:0] w, bt;
    logic [NB-1:0] st, last;
    last = in_s[len-1];
    nout = len + (((o != 0) && ((last >> (NB - o)) != 0)) ? 1 : 0);
    for (int k = 0; k < nout; k++) begin
      w = '0; st = '0;
      for (int b = 0; b < NB; b++) begin
        src = k * NB + b - o;
        if (src >= 0 && src < len * NB) begin
          bt = in_d[src / NB];
          w[8*b +: 8] = bt[8*(src % NB) +: 8];
          st[b] = in_s[src / NB][src % NB];
        end
      end
      exp_q.push_back({w, st});
    end
  endtask

  // ---------------- environment: enable / pop_ready ----------------
  initial begin
    bit en;
    enable_i = 1'b0; pop_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #2;
      en = force_en || (en_pct == 0) || ($urandom_range(0, 99) >= en_pct);
      enable_i    = en;
      pop_ready_i = en && ((bp_pct == 0) || ($urandom_range(0, 99) >= bp_pct));
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    bit hold = 0, acc = 0;
    logic [W-1:0] held, e;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_i || abort) begin hold = 0; acc = 0; continue; end
      if (hold) begin
        check("hold_valid", W'(pop_valid_o), W'(1));
        check("hold_word", {pop_data_o, pop_strb_o}, held);
      end
      if (acc) check("latency", W'(pop_valid_o), W'(1));
      if (!busy_o) check("idle_no_ready", W'(push_ready_o), W'(0));
      if (pop_valid_o && pop_ready_i) begin
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_pop", W'(1), W'(0));
        else begin
          e = exp_q.pop_front();
          check("pop_word", {pop_data_o, pop_strb_o}, e);
        end
      end
      if (done_o) begin
        done_cnt++;
        check("done_expected", W'(expect_done), W'(1));
        check("done_drained", W'(exp_q.size()), W'(0));
        if (!zero_len) check("done_after_pop", W'(cyc - last_pop_cyc), W'(1));
        expect_done = 0;
      end
      hold = pop_valid_o && !pop_ready_i;
      held = {pop_data_o, pop_strb_o};
      acc  = push_valid_i && push_ready_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic gen_beats(input int len, input int smode);
    logic [BW-1:0] d;
    in_d.delete(); in_s.delete();
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < BW / 32; j++) d[32*j +: 32] = $urandom;
      in_d.push_back(d);
      if (smode == 0)      in_s.push_back('1);
      else if (smode == 2) in_s.push_back(32'h0FFF_FFFF);
      else                 in_s.push_back(($urandom_range(0, 2) == 0) ? NB'($urandom) : '1);
    end
  endtask

  task automatic do_start(input int o, input int len);
    force_en = 1; start_i = 1; offset_i = 5'(o); len_i = LENW'(len);
    tick();
    start_i = 0; force_en = 0;
  endtask

  // abort_kind: 0 none, 1 async reset, 2 sync clear (before beat 2)
  task automatic run_tile(input int o, input int len, input bit spurious, input int abort_kind);
    int budget, d0;
    bit accepted;
    model_tile(o, len);
    zero_len = 0; expect_done = 1;
    do_start(o, len);
    for (int i = 0; i < len; i++) begin
      if (abort_kind != 0 && i == 2) begin
        push_valid_i = 0;
        if (abort_kind == 1) begin
          #2 rst_i = 1;
          #1;
          check("rst_pop_valid", W'(pop_valid_o), W'(0));
          check("rst_busy", W'(busy_o), W'(0));
          exp_q.delete(); expect_done = 0;
          tick(); tick();
          rst_i = 0;
        end else begin
          abort = 1; clear_i = 1;
          tick();
          clear_i = 0;
          check("clr_pop_valid", W'(pop_valid_o), W'(0));
          check("clr_busy", W'(busy_o), W'(0));
          exp_q.delete(); expect_done = 0; abort = 0;
        end
        repeat (6) tick();
        return;
      end
      if ($urandom_range(0, 3) == 0) begin push_valid_i = 0; tick(); end
      push_valid_i = 1; push_data_i = in_d[i]; push_strb_i = in_s[i];
      if (spurious && i == 1) begin start_i = 1; offset_i = 5'(o ^ 5); len_i = 2; end
      budget = 0; accepted = 0;
      while (!accepted && budget < 300) begin
        @(negedge clk_i); accepted = push_ready_o;
        tick(); budget++;
      end
      start_i = 0;
      if (!accepted) begin
        check("push_timeout", W'(0), W'(1));
        push_valid_i = 0;
        return;
      end
    end
    push_valid_i = 0;
    d0 = done_cnt; budget = 0;
    while (done_cnt == d0 && budget < 300) begin tick(); budget++; end
    check("tile_done_seen", W'(done_cnt - d0), W'(1));
    check("tile_queue_empty", W'(exp_q.size()), W'(0));
    exp_q.delete();
    repeat (2) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] e;
    logic [BW-1:0] a;
    rst_i = 1; clear_i = 0; start_i = 0; offset_i = 0; len_i = 0;
    push_data_i = '0; push_strb_i = '0; push_valid_i = 0;
    #8;
    check("reset_pop_valid", W'(pop_valid_o), W'(0));
    check("reset_pop_word", {pop_data_o, pop_strb_o}, W'(0));
    check("reset_busy_done", W'({busy_o, done_o, push_ready_o}), W'(0));
    tick(); tick();
    rst_i = 0;
    tick();

    // o=0 pass-through, full throughput
    gen_beats(3, 0);
    model_tile(0, 3);
    check("pin_o0_count", W'(exp_q.size()), W'(3));
    e = exp_q[1];
    check("pin_o0_word1", e, {in_d[1], 32'hFFFF_FFFF});
    exp_q.delete();
    run_tile(0, 3, 0, 0);

    // o=4 with byte-indexed beats A and B
    in_d.delete(); in_s.delete();
    for (int j = 0; j < NB; j++) a[8*j +: 8] = 8'(j);
    in_d.push_back(a);
    for (int j = 0; j < NB; j++) a[8*j +: 8] = 8'(8'h20 + j);
    in_d.push_back(a);
    in_s.push_back('1); in_s.push_back('1);
    model_tile(4, 2);
    check("pin_ab_count", W'(exp_q.size()), W'(3));
    e = exp_q[0]; check("pin_ab_out0_strb", W'(e[NB-1:0]), W'(32'hFFFF_FFF0));
    check("pin_ab_out0_hi", W'(e[W-1 -: 8]), W'(8'h1B));
    check("pin_ab_out0_lo", W'(e[NB +: 40]), W'(40'h00_0000_0000));
    e = exp_q[1]; check("pin_ab_out1_lo", W'(e[NB +: 40]), W'(40'h20_1F1E_1D1C));
    check("pin_ab_out1_strb", W'(e[NB-1:0]), W'(32'hFFFF_FFFF));
    e = exp_q[2]; check("pin_ab_out2", W'(e[NB +: 40]), W'(40'h00_3F3E_3D3C));
    check("pin_ab_out2_strb", W'(e[NB-1:0]), W'(32'h0000_000F));
    exp_q.delete();
    run_tile(4, 2, 0, 0);

    // o=4, top four bytes disabled: no flush
    gen_beats(1, 2);
    model_tile(4, 1);
    check("pin_noflush_count", W'(exp_q.size()), W'(1));
    exp_q.delete();
    run_tile(4, 1, 0, 0);

    // o=31 with back-pressure
    bp_pct = 50;
    gen_beats(4, 0);
    model_tile(31, 4);
    check("pin_o31_count", W'(exp_q.size()), W'(5));
    exp_q.delete();
    run_tile(31, 4, 0, 0);
    bp_pct = 0;

    // len=0: done next cycle, no outputs
    zero_len = 1; expect_done = 1;
    do_start(9, 0);
    check("len0_done", W'({done_o, pop_valid_o, busy_o}), W'(3'b100));
    repeat (3) tick();

    // start while busy is ignored
    gen_beats(4, 1);
    run_tile(5, 4, 1, 0);

    // async reset mid-tile, then clean tile
    gen_beats(4, 0);
    run_tile(7, 4, 0, 1);
    gen_beats(2, 0);
    model_tile(3, 2);
    e = exp_q[0];
    check("pin_post_rst_strb", W'(e[NB-1:0]), W'(32'hFFFF_FFF8));
    exp_q.delete();
    run_tile(3, 2, 0, 0);

    // sync clear mid-tile, then clean tile
    gen_beats(4, 0);
    run_tile(9, 4, 0, 2);
    gen_beats(3, 1);
    run_tile(12, 3, 0, 0);

    // randomized tiles with back-pressure and enable pauses
    bp_pct = 30; en_pct = 20;
    for (int t = 0; t < 20; t++) begin
      int o, len;
      o   = $urandom_range(0, NB - 1);
      len = $urandom_range(1, 6);
      gen_beats(len, $urandom_range(0, 1));
      run_tile(o, len, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
